uart_tx_serializer: RTL
=======================

Name: uart_tx_serializer

Overview:
- UART transmitter; the transmit-side counterpart of the oversampling UART receiver used for inter-board game links.
- Accepts one parallel byte through a valid/ready handshake and serializes it onto tx_o.
- Frame format: 1 start bit, DATA_BITS data bits sent LSB first, an optional parity bit, 1 stop bit.
- Bit timing comes from the shared baud-rate oversample tick: each bit lasts exactly OVERSAMPLE ticks, matching the receiver's sample counter.

Parameters:
- DATA_BITS, 8: number of data bits per frame (5..9).
- OVERSAMPLE, 16: tick_i pulses per bit period (power of two, 4..16).

Ports:
- clk_i  input  1  system clock.
- rst_ni  input  1  asynchronous active-low reset.
- tick_i  input  1  oversample enable pulse, one clk_i cycle wide.
- data_i  input  DATA_BITS  byte to transmit; sampled on handshake.
- valid_i  input  1  data_i is valid.
- ready_o  output  1  block can accept a byte (high only in IDLE).
- tx_o  output  1  serial line; idles high.
- busy_o  output  1  frame in progress (any state other than IDLE).
- done_o  output  1  one-cycle pulse when the stop bit completes.

Behaviour:
- Reset (rst_ni low, asynchronous):
  - state=IDLE, tx_o=1, ready_o=1, busy_o=0, done_o=0.
  - Shift register, tick counter and bit counter cleared.
  - A reset in mid-frame forces tx_o high immediately with no partial stop bit.
- Handshake: transfer occurs on a clk_i edge with valid_i && ready_o.
  - data_i is latched into the shift register.
  - State becomes START on that edge; tx_o=0 from the following cycle.
  - valid_i while busy is ignored; data_i is don't-care outside a transfer.
- Tick counter:
  - Width $clog2(OVERSAMPLE); cleared on every state entry.
  - Increments only on tick_i.
  - When tick_i is high and the count equals OVERSAMPLE-1, the bit ends, the counter wraps to 0 and the FSM advances.
- Bit duration: each bit holds for exactly OVERSAMPLE tick_i pulses. The first bit may additionally include fewer than one tick interval of latency after acceptance.
- FSM states and outputs:
  - IDLE: tx_o=1, ready_o=1. Goes to START on handshake.
  - START: tx_o=0. At bit end goes to DATA with bit counter=0.
  - DATA: tx_o=shift[0]. At bit end, shift right by 1 and increment the bit counter; when the bit counter reaches DATA_BITS-1, go to PARITY (feature compiled in) or STOP (feature compiled out).
  - PARITY: tx_o=parity bit. At bit end goes to STOP.
  - STOP: tx_o=1. At bit end goes to IDLE, and done_o=1 for that single cycle.
- Back-to-back frames: a byte presented with valid_i held high is accepted on the first IDLE cycle, so there is a one-clk gap minimum between frames. No minimum idle time in ticks is required.
- tick_i arriving in the same cycle as a handshake is not counted toward the start bit.
- Registered outputs: tx_o, ready_o, busy_o and done_o are registered (Moore); there is no combinational path from any input to any output.
- Frame length: 1+DATA_BITS+1 bits (plus 1 with parity), i.e. 160 ticks for the defaults.

Optional Feature:
- Macro: UART_TX_PARITY_EN.
- Defined:
  - PARITY state present.
  - The parity bit is even parity, the XOR of all DATA_BITS bits of the latched byte, computed at handshake.
  - Frame is 11 bits (176 ticks at defaults).
- Undefined:
  - No PARITY state and no parity logic.
  - DATA goes directly to STOP; frame is 10 bits.

Test Plan:
- Reset value checks: hold rst_ni=0, then release -> tx_o=1, ready_o=1, busy_o=0, done_o=0; no toggling on tx_o across 50 ticks with valid_i=0.
- Single frame, tick_i high every cycle, data_i=8'hA5 -> tx_o sequence per 16-cycle bit: 0,1,0,1,0,0,1,0,1,1. Expect done_o pulse exactly once, 160 cycles after the start bit begins; ready_o low throughout.
- Sparse tick (tick_i every 4th cycle), data_i=8'h00 -> start plus 8 data bits are low for 9*16 ticks (576 clk). Stop bit high for 64 clk, then IDLE.
- Back-to-back frames: valid_i held high with data 8'h3C then 8'hC3 -> second start bit begins one clk after done_o. Both frames are bit-exact, and data_i changes mid-frame have no effect.
- Mid-frame reset: assert rst_ni=0 during data bit 3 of 8'hFF -> tx_o=1 asynchronously. After release, ready_o=1 and a new 8'h81 frame is transmitted correctly.
- With UART_TX_PARITY_EN: 8'h07 -> parity bit=1; 8'h03 -> parity bit=0; frame length 176 ticks. Without the macro, the stop bit immediately follows data bit 7.

Source files
------------

// File: rtl/uart_tx_serializer.sv
// ---------------------------------------------------------------------------
// uart_tx_serializer
//
// UART transmitter for the inter-board game link. Accepts one parallel word
// over a valid/ready handshake and shifts it out on tx_o as:
//   start (0), DATA_BITS data bits LSB first, [even parity], stop (1).
// Every bit lasts exactly OVERSAMPLE pulses of tick_i, the same oversample
// tick the companion receiver counts with.
//
// Optional feature (compile-time macro UART_TX_PARITY_EN):
//   defined   -> adds a PARITY state carrying the XOR of the latched data bits
//   undefined -> no parity logic, DATA goes straight to STOP
//
// Parameters:
//   DATA_BITS  : data bits per frame (5..9)
//   OVERSAMPLE : tick_i pulses per bit period (power of two, 4..16)
//
// Ports:
//   clk_i    : system clock
//   rst_ni   : asynchronous active-low reset
//   tick_i   : oversample enable, one clk_i cycle wide
//   data_i   : word to transmit, captured on the handshake
//   valid_i  : data_i is valid
//   ready_o  : block can accept a word (IDLE only)
//   tx_o     : serial line, idles high
//   busy_o   : frame in progress
//   done_o   : one-cycle pulse when the stop bit completes
//
// All outputs are registered and decoded from the next state, so there is no
// combinational path from any input to any output.
// ---------------------------------------------------------------------------
module uart_tx_serializer #(
  parameter int DATA_BITS  = 8,
  parameter int OVERSAMPLE = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  input  logic                 tick_i,
  input  logic [DATA_BITS-1:0] data_i,
  input  logic                 valid_i,
  output logic                 ready_o,
  output logic                 tx_o,
  output logic                 busy_o,
  output logic                 done_o
);

  localparam int CNT_W = $clog2(OVERSAMPLE);
  localparam int BIT_W = $clog2(DATA_BITS);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

`ifdef UART_TX_PARITY_EN
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;
`else
  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } state_t;
`endif

  state_t                 state_q, state_d;
  logic [DATA_BITS-1:0]   shift_q, shift_d;
  logic [CNT_W-1:0]       cnt_q, cnt_d;
  logic [BIT_W-1:0]       bitc_q, bitc_d;
  logic                   tx_q, tx_d;
  logic                   ready_q, ready_d;
  logic                   busy_q, busy_d;
  logic                   done_q, done_d;
  logic                   bit_end;
`ifdef UART_TX_PARITY_EN
  logic                   parity_q, parity_d;
`endif

  // A bit ends on the tick that would take the counter past OVERSAMPLE-1.
  assign bit_end = tick_i && (cnt_q == CNT_LAST);

  always_comb begin
    state_d  = state_q;
    shift_d  = shift_q;
    cnt_d    = cnt_q;
    bitc_d   = bitc_q;
    done_d   = 1'b0;
`ifdef UART_TX_PARITY_EN
    parity_d = parity_q;
`endif

    // Count ticks only inside a frame; a tick coinciding with the
    // handshake is ignored because the FSM is still in IDLE then.
    if (state_q != IDLE && tick_i) begin
      cnt_d = cnt_q + 1'b1;
    end

    case (state_q)
      IDLE: begin
        if (valid_i) begin
          state_d  = START;
          shift_d  = data_i;
          cnt_d    = '0;
`ifdef UART_TX_PARITY_EN
          parity_d = ^data_i;
`endif
        end
      end
      START: begin
        if (bit_end) begin
          state_d = DATA;
          cnt_d   = '0;
          bitc_d  = '0;
        end
      end
      DATA: begin
        if (bit_end) begin
          shift_d = shift_q >> 1;
          cnt_d   = '0;
          if (bitc_q == BIT_LAST) begin
            bitc_d  = '0;
`ifdef UART_TX_PARITY_EN
            state_d = PARITY;
`else
            state_d = STOP;
`endif
          end else begin
            bitc_d = bitc_q + 1'b1;
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_d = STOP;
          cnt_d   = '0;
        end
      end
`endif
      STOP: begin
        if (bit_end) begin
          state_d = IDLE;
          cnt_d   = '0;
          done_d  = 1'b1;
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase

    // Moore outputs decoded from the next state so they line up with it.
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
`ifdef UART_TX_PARITY_EN
      PARITY:  tx_d = parity_d;
`endif
      default: tx_d = 1'b1;
    endcase
    ready_d = (state_d == IDLE);
    busy_d  = (state_d != IDLE);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      shift_q  <= '0;
      cnt_q    <= '0;
      bitc_q   <= '0;
      tx_q     <= 1'b1;
      ready_q  <= 1'b1;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_q <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      shift_q  <= shift_d;
      cnt_q    <= cnt_d;
      bitc_q   <= bitc_d;
      tx_q     <= tx_d;
      ready_q  <= ready_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
`ifdef UART_TX_PARITY_EN
      parity_q <= parity_d;
`endif
    end
  end

  assign tx_o    = tx_q;
  assign ready_o = ready_q;
  assign busy_o  = busy_q;
  assign done_o  = done_q;

endmodule
